// File: rtl/mcpu_program_loader.sv
// Boot loader for the MCPU: zero-fills program RAM, then loads a framed
// image (count, payload, XOR checksum) and releases the core once it verifies.
module mcpu_program_loader #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 8,
  parameter int RAM_SIZE  = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_word,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORD_SIZE-1:0] ram_wdata,
  output logic                 cpu_reset,
  output logic                 done,
  output logic                 error,
  output logic [ADDR_SIZE:0]   words_loaded
);

  localparam int CW = ADDR_SIZE + 1;
  localparam logic [CW-1:0]        RAM_LEN = CW'(RAM_SIZE);
  localparam logic [WORD_SIZE-1:0] MAX_LEN = WORD_SIZE'(RAM_SIZE);

  typedef enum logic [2:0] {
    S_CLEAR, S_HEADER, S_LOAD, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        count, count_n;
  logic [CW-1:0]        index, index_n;
  logic [CW-1:0]        clr_cnt, clr_cnt_n;
  logic [WORD_SIZE-1:0] checksum, checksum_n;
  logic [CW-1:0]        words_loaded_n;
  logic                 ram_we_n;
  logic [ADDR_SIZE-1:0] ram_addr_n;
  logic [WORD_SIZE-1:0] ram_wdata_n;
  logic                 cpu_reset_n, done_n, error_n;
  logic                 xfer;

  assign in_ready = (state == S_HEADER) || (state == S_LOAD) || (state == S_CHECK);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_n        = state;
    count_n        = count;
    index_n        = index;
    clr_cnt_n      = clr_cnt;
    checksum_n     = checksum;
    words_loaded_n = words_loaded;
    ram_we_n       = 1'b0;
    ram_addr_n     = ram_addr;
    ram_wdata_n    = ram_wdata;
    cpu_reset_n    = cpu_reset;
    done_n         = done;
    error_n        = error;

    case (state)
      S_CLEAR: begin
        // clr_cnt is one bit wider than the address so the final word is reachable
        if (clr_cnt < RAM_LEN) begin
          ram_we_n    = 1'b1;
          ram_addr_n  = clr_cnt[ADDR_SIZE-1:0];
          ram_wdata_n = '0;
          clr_cnt_n   = clr_cnt + CW'(1);
        end else begin
          state_n = S_HEADER;
        end
      end
      S_HEADER: begin
        if (xfer) begin
          checksum_n = in_word;
          if ((in_word == '0) || (in_word > MAX_LEN)) begin
            state_n = S_ERROR;
            error_n = 1'b1;
          end else begin
            state_n = S_LOAD;
            count_n = in_word[CW-1:0];
            index_n = '0;
          end
        end
      end
      S_LOAD: begin
        if (xfer) begin
          ram_we_n       = 1'b1;
          ram_addr_n     = index[ADDR_SIZE-1:0];
          ram_wdata_n    = in_word;
          checksum_n     = checksum ^ in_word;
          index_n        = index + CW'(1);
          words_loaded_n = words_loaded + CW'(1);
          if (index_n == count) state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        if (xfer) begin
          if (in_word == checksum) begin
            state_n     = S_DONE;
            done_n      = 1'b1;
            cpu_reset_n = 1'b0;
          end else begin
            state_n = S_ERROR;
            error_n = 1'b1;
          end
        end
      end
      S_DONE:  ;
      S_ERROR: ;
      default: state_n = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_CLEAR;
      count        <= '0;
      index        <= '0;
      clr_cnt      <= '0;
      checksum     <= '0;
      words_loaded <= '0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state        <= state_n;
      count        <= count_n;
      index        <= index_n;
      clr_cnt      <= clr_cnt_n;
      checksum     <= checksum_n;
      words_loaded <= words_loaded_n;
      ram_we       <= ram_we_n;
      ram_addr     <= ram_addr_n;
      ram_wdata    <= ram_wdata_n;
      cpu_reset    <= cpu_reset_n;
      done         <= done_n;
      error        <= error_n;
    end
  end

endmodule

// File: doc/mcpu_program_loader.md
Name: mcpu_program_loader

Overview:
Boot-time stage directly upstream of the MCPU core and its RAM. After reset it zero-fills program RAM, then accepts a framed instruction stream over a valid/ready interface: a count word, the instruction words, and an XOR checksum word. It writes the instruction words to RAM from address 0 and holds the CPU in reset until a valid image has loaded. It is the hardware replacement for loading and zeroing memory from the bench.

Parameters:
WORD_SIZE, 16, width of RAM words, instruction words and stream words
ADDR_SIZE, 8, RAM address width
RAM_SIZE, 256, number of RAM words; also the maximum legal program length

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  stream word present
in_ready  output  1  loader accepts a word this cycle
in_word  input  WORD_SIZE  stream data
ram_we  output  1  RAM write enable (registered)
ram_addr  output  ADDR_SIZE  RAM write address (registered)
ram_wdata  output  WORD_SIZE  RAM write data (registered)
cpu_reset  output  1  drives the MCPU reset; 1 holds the core in reset
done  output  1  image loaded and verified; sticky
error  output  1  bad length or checksum; sticky
words_loaded  output  ADDR_SIZE+1  payload words written so far

Behaviour:
- Clock is clk; reset is synchronous and active-high. There is one clock domain.
- Reset values: ram_we=0, ram_addr=0, ram_wdata=0, cpu_reset=1, done=0, error=0, words_loaded=0; internal state goes to CLEAR with count, index and checksum at 0.
- A transfer occurs on a rising edge where in_valid=1 and in_ready=1.
- in_ready is combinational from state: it is 1 only in HEADER, LOAD and CHECK.
- CLEAR: runs for RAM_SIZE cycles. Each cycle asserts ram_we=1 with ram_wdata=0, and ram_addr steps 0..RAM_SIZE-1. The cycle after address RAM_SIZE-1 is written, ram_we=0 and the state becomes HEADER.
- HEADER: the accepted word is the count N, and checksum is set to N.
  - N==0 or N>RAM_SIZE -> ERROR.
  - Otherwise -> LOAD with index=0.
- LOAD: each accepted word w sets ram_we=1, ram_addr=index and ram_wdata=w in the next cycle, so the RAM write lands one edge after acceptance.
  - Also on acceptance: checksum ^= w, index++, words_loaded++.
  - When the Nth word is accepted -> CHECK.
  - Cycles without a transfer drive ram_we=0, so there are no duplicate writes.
- CHECK: compares the accepted word with checksum.
  - Equal -> DONE.
  - Not equal -> ERROR.
- DONE: done=1 and cpu_reset=0 from the cycle after the check word is accepted. in_ready=0 and ram_we=0. Remains here until reset.
- ERROR: error=1 and cpu_reset=1 from the cycle after the offending word. in_ready=0. Remains here until reset. The RAM keeps any partial image.
- done and error are never both 1.
- cpu_reset=1 in every state except DONE.
- Addressing: index is ADDR_SIZE+1 bits wide. N==RAM_SIZE is legal and writes addresses 0..RAM_SIZE-1. ram_addr never wraps during LOAD.
- Reset in any state, including mid-CLEAR or mid-LOAD, aborts the load and restarts from CLEAR with all reset values.
- in_word is ignored whenever in_ready=0.

Test Plan:
1. Release reset with in_valid=1 held -> exactly 256 consecutive cycles with ram_we=1, ram_wdata=0, ram_addr 0..255; in_ready=0 throughout; in_ready=1 on the next cycle and no word accepted earlier.
2. Stream 5, 16'h047D, 16'h050C, 16'h0605, 16'h9746, 16'hAF75, then the checksum (XOR of all six words) -> RAM[0..4] hold those five words in order; words_loaded=5; done=1 and cpu_reset=0 one cycle after the checksum is accepted.
3. Same image with the checksum bit 0 flipped -> error=1, cpu_reset stays 1, done=0, in_ready=0 afterwards, and no further writes when in_valid toggles.
4. Count 0 -> error=1 with no RAM writes. Count 257 -> error=1. Count 256 with a correct checksum -> last write at ram_addr=255, done=1, no wrap to 0.
5. Image of scenario 2 with in_valid deasserted for 1–3 random cycles between words -> exactly five writes, identical RAM contents, done=1.
6. Assert reset for one cycle after the 3rd payload word -> outputs return to reset values, CLEAR reruns and zeroes RAM[0..2], and a subsequent full load completes with done=1.
